// File: rtl/counter_pkg.sv
// counter_pkg: encodings and step classification shared by the counter bank.
//   dir_e   : count direction carried on up_dn (UP = 1, DOWN = 0)
//   mode_e  : terminal behaviour carried on sat_mode (SAT = 1, WRAP = 0)
//   step_e  : kind of update a channel performs on a given clock edge
//   classify: picks the step kind from the channel's control inputs
package counter_pkg;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_e;

  typedef enum logic {
    WRAP = 1'b0,
    SAT  = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    STEP_HOLD    = 3'd0,
    STEP_LOAD    = 3'd1,
    STEP_INC     = 3'd2,
    STEP_DEC     = 3'd3,
    STEP_TERM_UP = 3'd4,
    STEP_TERM_DN = 3'd5
  } step_e;

  // Load beats enable; an enabled step becomes a terminal event when the
  // count cannot move further in the requested direction.
  function automatic step_e classify(
    input logic load,
    input logic enab,
    input dir_e dir,
    input logic cnt_lt_mod,
    input logic cnt_zero
  );
    step_e kind;
    kind = STEP_HOLD;
    if (load) begin
      kind = STEP_LOAD;
    end else if (enab) begin
      if (dir == UP) begin
        kind = cnt_lt_mod ? STEP_INC : STEP_TERM_UP;
      end else begin
        kind = cnt_zero ? STEP_TERM_DN : STEP_DEC;
      end
    end
    return kind;
  endfunction

endpackage

// File: rtl/counter_chan.sv
// counter_chan: one up/down counter channel with wrap/saturate terminal
// handling, a one-cycle terminal-count pulse and a sticky overflow flag.
//   clk, rst_n      : clock, synchronous active-low reset
//   load, cnt_in    : load strobe and value (highest priority after reset)
//   enab, up_dn     : count enable and direction (1 = up)
//   sat_mode        : 1 = saturate at the terminal value, 0 = wrap
//   modulus         : terminal value for up counting, reload for down wrap
//   ovf_clr         : clears the sticky flag unless a terminal event sets it
//   cnt, tc, ovf    : registered count, terminal pulse, sticky flag
module counter_chan
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enab,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             ovf_clr,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf
);

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             ovf;
  } chan_state_t;

  chan_state_t state_reg;
  chan_state_t state_next;

  // Entire next-state computation for one channel. Arithmetic stays in
  // WIDTH bits: an increment only happens below modulus and a decrement only
  // above zero, so neither can carry out.
  function automatic chan_state_t next_state(
    input chan_state_t      cur,
    input logic             ld,
    input logic             en,
    input dir_e             dir,
    input mode_e            mode,
    input logic             clr,
    input logic [WIDTH-1:0] ld_val,
    input logic [WIDTH-1:0] term_val
  );
    chan_state_t nxt;
    step_e       kind;
    logic        term;

    kind = classify(ld, en, dir, cur.cnt < term_val, cur.cnt == '0);
    nxt  = cur;
    term = 1'b0;

    case (kind)
      STEP_LOAD:    nxt.cnt = ld_val;
      STEP_INC:     nxt.cnt = cur.cnt + 1'b1;
      STEP_DEC:     nxt.cnt = cur.cnt - 1'b1;
      STEP_TERM_UP: begin
        term    = 1'b1;
        nxt.cnt = (mode == SAT) ? term_val : '0;
      end
      STEP_TERM_DN: begin
        term    = 1'b1;
        nxt.cnt = (mode == SAT) ? '0 : term_val;
      end
      default:      nxt.cnt = cur.cnt;
    endcase

    nxt.tc  = term;
    // A terminal event in the same cycle as a clear keeps the flag set.
    nxt.ovf = term | (cur.ovf & ~clr);
    return nxt;
  endfunction

  always_comb begin
    state_next = next_state(state_reg, load, enab, dir_e'(up_dn),
                            mode_e'(sat_mode), ovf_clr, cnt_in, modulus);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= '0;
    end else begin
      state_reg <= state_next;
    end
  end

  assign cnt = state_reg.cnt;
  assign tc  = state_reg.tc;
  assign ovf = state_reg.ovf;

endmodule

// File: rtl/counter_bank.sv
// counter_bank: CHANNELS independent counter channels sharing one clock.
//   clk, rst_n : clock, synchronous active-low reset
//   load, enab, up_dn, sat_mode, ovf_clr : one control bit per channel
//   cnt_in, modulus : per-channel WIDTH-bit fields, channel i at [i*WIDTH +: WIDTH]
//   cnt_out    : registered counts, same packing
//   tc, ovf    : registered terminal pulse and sticky flag, one bit per channel
module counter_bank
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS-1:0]       enab,
  input  logic [CHANNELS-1:0]       up_dn,
  input  logic [CHANNELS-1:0]       sat_mode,
  input  logic [CHANNELS*WIDTH-1:0] cnt_in,
  input  logic [CHANNELS*WIDTH-1:0] modulus,
  input  logic [CHANNELS-1:0]       ovf_clr,
  output logic [CHANNELS*WIDTH-1:0] cnt_out,
  output logic [CHANNELS-1:0]       tc,
  output logic [CHANNELS-1:0]       ovf
);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      counter_chan #(
        .WIDTH(WIDTH)
      ) u_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load[gi]),
        .enab     (enab[gi]),
        .up_dn    (up_dn[gi]),
        .sat_mode (sat_mode[gi]),
        .ovf_clr  (ovf_clr[gi]),
        .cnt_in   (cnt_in[gi*WIDTH +: WIDTH]),
        .modulus  (modulus[gi*WIDTH +: WIDTH]),
        .cnt      (cnt_out[gi*WIDTH +: WIDTH]),
        .tc       (tc[gi]),
        .ovf      (ovf[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: directed scenarios followed by randomized traffic. The
// driver applies one input vector per cycle and pushes the reference model's
// expected outputs into a queue; the monitor pops one entry after each clock
// edge and compares it with the DUT.
module tb_counter_bank;
  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int VW       = CHANNELS * WIDTH;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [CHANNELS-1:0] load, enab, up_dn, sat_mode, ovf_clr;
  logic [VW-1:0]       cnt_in, modulus;
  logic [VW-1:0]       cnt_out;
  logic [CHANNELS-1:0] tc, ovf;

  // staging copies written by the scenario code, applied at the next negedge
  logic                st_rst_n;
  logic [CHANNELS-1:0] st_load, st_enab, st_up_dn, st_sat, st_clr;
  logic [VW-1:0]       st_cnt_in, st_modulus;

  // reference model state
  int m_cnt[CHANNELS];
  bit m_ovf[CHANNELS];

  typedef struct {
    logic [VW-1:0]       cnt;
    logic [CHANNELS-1:0] tc;
    logic [CHANNELS-1:0] ovf;
    int                  dch;
    int                  dcnt;
    bit                  dtc;
    bit                  dovf;
    int                  id;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   n_issue = 0;

  counter_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .enab     (enab),
    .up_dn    (up_dn),
    .sat_mode (sat_mode),
    .cnt_in   (cnt_in),
    .modulus  (modulus),
    .ovf_clr  (ovf_clr),
    .cnt_out  (cnt_out),
    .tc       (tc),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [VW-1:0] act,
                     input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s txn %0d actual %h expected %h", name, id, act, exp);
    end
  endtask

  // Apply the staged inputs for one cycle and record what the outputs must
  // be after the following rising edge. dch >= 0 adds a hand-computed
  // expectation for that channel.
  task automatic step(input int dch = -1, input int dcnt = 0,
                      input bit dtc = 1'b0, input bit dovf = 1'b0);
    exp_t e;
    @(negedge clk);
    rst_n    = st_rst_n;
    load     = st_load;
    enab     = st_enab;
    up_dn    = st_up_dn;
    sat_mode = st_sat;
    ovf_clr  = st_clr;
    cnt_in   = st_cnt_in;
    modulus  = st_modulus;

    e.cnt = '0;
    e.tc  = '0;
    e.ovf = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      int c;
      int m;
      int n;
      bit term;
      c    = m_cnt[i];
      m    = int'(st_modulus[i*WIDTH +: WIDTH]);
      n    = c;
      term = 1'b0;
      if (!st_rst_n) begin
        n        = 0;
        m_ovf[i] = 1'b0;
      end else begin
        if (st_load[i]) begin
          n = int'(st_cnt_in[i*WIDTH +: WIDTH]);
        end else if (st_enab[i]) begin
          if (st_up_dn[i]) begin
            if (c < m) n = c + 1;
            else begin term = 1'b1; n = st_sat[i] ? m : 0; end
          end else begin
            if (c > 0) n = c - 1;
            else begin term = 1'b1; n = st_sat[i] ? 0 : m; end
          end
        end
        m_ovf[i] = term || (m_ovf[i] && !st_clr[i]);
      end
      m_cnt[i]                 = n;
      e.cnt[i*WIDTH +: WIDTH]  = WIDTH'(n);
      e.tc[i]                  = term;
      e.ovf[i]                 = m_ovf[i];
    end
    e.dch  = dch;
    e.dcnt = dcnt;
    e.dtc  = dtc;
    e.dovf = dovf;
    e.id   = n_issue;
    n_issue++;
    q.push_back(e);
  endtask

  // monitor: one comparison set per issued vector, sampled 1 ns after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        $display("txn %0d cnt=%h tc=%b ovf=%b", e.id, cnt_out, tc, ovf);
        chk("cnt_out", e.id, cnt_out, e.cnt);
        chk("tc", e.id, VW'(tc), VW'(e.tc));
        chk("ovf", e.id, VW'(ovf), VW'(e.ovf));
        if (e.dch >= 0) begin
          chk("dir_cnt", e.id, VW'(cnt_out[e.dch*WIDTH +: WIDTH]), VW'(e.dcnt));
          chk("dir_tc", e.id, VW'(tc[e.dch]), VW'(e.dtc));
          chk("dir_ovf", e.id, VW'(ovf[e.dch]), VW'(e.dovf));
        end
      end
    end
  end

  initial begin
    int exp_up[7];
    int exp_dn[4];
    int waited;
    exp_up = '{1, 2, 3, 4, 5, 0, 1};
    exp_dn = '{1, 0, 0, 0};

    rst_n = 1'b0; load = '0; enab = '0; up_dn = '0; sat_mode = '0;
    ovf_clr = '0; cnt_in = '0; modulus = '0;
    st_rst_n = 1'b0; st_load = '0; st_enab = '0; st_up_dn = '0; st_sat = '0;
    st_clr = '0; st_cnt_in = '0; st_modulus = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
    end

    // reset state
    step(0, 0, 1'b0, 1'b0);
    step(3, 0, 1'b0, 1'b0);
    st_rst_n = 1'b1;

    // ch0 up, wrap, modulus 5, enabled straight out of reset
    st_modulus[0 +: WIDTH] = 8'd5;
    st_up_dn[0] = 1'b1;
    st_sat[0]   = 1'b0;
    st_enab[0]  = 1'b1;
    for (int k = 0; k < 7; k++) step(0, exp_up[k], k == 5, k >= 5);
    st_enab[0] = 1'b0;

    // ch1 down, saturate, load 2 then four enabled steps
    st_sat[1] = 1'b1;
    st_up_dn[1] = 1'b0;
    st_cnt_in[WIDTH +: WIDTH] = 8'd2;
    st_load[1] = 1'b1;
    step(1, 2, 1'b0, 1'b0);
    st_load[1] = 1'b0;
    st_enab[1] = 1'b1;
    for (int k = 0; k < 4; k++) step(1, exp_dn[k], k >= 2, k >= 2);
    st_enab[1] = 1'b0;

    // ch2 load above modulus, then an up step wraps to 0
    st_modulus[2*WIDTH +: WIDTH] = 8'd10;
    st_cnt_in[2*WIDTH +: WIDTH]  = 8'd200;
    st_up_dn[2] = 1'b1;
    st_sat[2]   = 1'b0;
    st_load[2]  = 1'b1;
    step(2, 200, 1'b0, 1'b0);
    st_load[2] = 1'b0;
    st_enab[2] = 1'b1;
    step(2, 0, 1'b1, 1'b1);
    st_enab[2] = 1'b0;

    // ch3 load beats enab; reset beats both
    st_modulus[3*WIDTH +: WIDTH] = 8'd20;
    st_cnt_in[3*WIDTH +: WIDTH]  = 8'd9;
    st_up_dn[3] = 1'b1;
    st_load[3]  = 1'b1;
    st_enab[3]  = 1'b1;
    step(3, 9, 1'b0, 1'b0);
    st_rst_n = 1'b0;
    st_clr[3] = 1'b1;
    step(3, 0, 1'b0, 1'b0);
    st_rst_n = 1'b1;
    st_load[3] = 1'b0;
    st_enab[3] = 1'b0;
    st_clr[3]  = 1'b0;

    // terminal event and clear together: set wins; clear alone then clears
    st_modulus[0 +: WIDTH] = 8'd3;
    st_cnt_in[0 +: WIDTH]  = 8'd3;
    st_load[0] = 1'b1;
    step(0, 3, 1'b0, 1'b0);
    st_load[0] = 1'b0;
    st_enab[0] = 1'b1;
    st_clr[0]  = 1'b1;
    step(0, 0, 1'b1, 1'b1);
    st_enab[0] = 1'b0;
    step(0, 0, 1'b0, 1'b0);
    st_clr[0] = 1'b0;

    // modulus 0: every enabled step is terminal and the count stays 0
    st_modulus[0 +: WIDTH] = 8'd0;
    st_enab[0]  = 1'b1;
    st_up_dn[0] = 1'b0;
    st_sat[0]   = 1'b1;
    step(0, 0, 1'b1, 1'b1);
    st_up_dn[0] = 1'b1;
    st_sat[0]   = 1'b0;
    step(0, 0, 1'b1, 1'b1);
    st_enab[0] = 1'b0;
    step(0, 0, 1'b0, 1'b1);

    // randomized traffic on all channels with mixed modes
    for (int i = 0; i < CHANNELS; i++)
      st_modulus[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 12));
    for (int k = 0; k < 400; k++) begin
      st_rst_n = ($urandom % 100) != 0;
      for (int i = 0; i < CHANNELS; i++) begin
        st_enab[i]  = ($urandom % 4) != 0;
        st_load[i]  = ($urandom % 16) == 0;
        st_up_dn[i] = $urandom % 2;
        st_sat[i]   = $urandom % 2;
        st_clr[i]   = ($urandom % 8) == 0;
        st_cnt_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        if (($urandom % 32) == 0)
          st_modulus[i*WIDTH +: WIDTH] = (($urandom % 4) == 0) ? WIDTH'(255)
                                         : WIDTH'($urandom_range(0, 12));
      end
      step();
    end

    // drain the scoreboard with a bounded wait
    st_rst_n = 1'b1; st_load = '0; st_enab = '0; st_clr = '0;
    waited = 0;
    while (q.size() > 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each channel count.
REQ-002 SHALL have parameter CHANNELS, default 4: number of independent counter channels.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port load, input, CHANNELS: per-channel load strobe.
REQ-006 SHALL have port enab, input, CHANNELS: per-channel count enable.
REQ-007 SHALL have port up_dn, input, CHANNELS: per-channel direction; 1 = up, 0 = down.
REQ-008 SHALL have port sat_mode, input, CHANNELS: per-channel mode; 1 = saturate, 0 = wrap.
REQ-009 SHALL have port cnt_in, input, CHANNELS*WIDTH: per-channel load value; channel i in bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port modulus, input, CHANNELS*WIDTH: per-channel terminal value, same packing.
REQ-011 SHALL have port ovf_clr, input, CHANNELS: per-channel clear of sticky overflow flag.
REQ-012 SHALL have port cnt_out, output, CHANNELS*WIDTH: registered per-channel count, same packing.
REQ-013 SHALL have port tc, output, CHANNELS: registered one-cycle terminal-count pulse.
REQ-014 SHALL have port ovf, output, CHANNELS: registered sticky terminal-event flag.

Function
REQ-015 SHALL operate each channel independently; no cross-channel interaction.
REQ-016 SHALL apply per-channel priority on each posedge: reset, then load, then enab, then hold.
REQ-017 SHALL, on load, set cnt_out[i] = cnt_in[i] next cycle, regardless of modulus; tc[i] = 0 that cycle.
REQ-018 SHALL, on enab with up_dn=1 and cnt < modulus, increment by 1 next cycle.
REQ-019 SHALL treat enab with up_dn=1 and cnt >= modulus as an up terminal event: next count is 0 in wrap mode, modulus in saturate mode.
REQ-020 SHALL, on enab with up_dn=0 and cnt > 0, decrement by 1 next cycle.
REQ-021 SHALL treat enab with up_dn=0 and cnt == 0 as a down terminal event: next count is modulus in wrap mode, 0 in saturate mode.
REQ-022 SHALL assert tc[i] for exactly the one cycle after each terminal event, and deassert it otherwise; consecutive terminal events give consecutive tc pulses.
REQ-023 SHALL set ovf[i] on any terminal event, hold it until ovf_clr[i]; set SHALL win over clear in the same cycle.
REQ-024 SHALL, with modulus = 0, hold count at 0 and treat every enabled step in either direction as a terminal event.
REQ-025 SHALL sample modulus, up_dn and sat_mode every cycle; changes take effect on the next enabled step with no latency.
REQ-026 SHALL perform all arithmetic in WIDTH bits; no carry beyond WIDTH is observable except via tc/ovf.

Reset
REQ-027 SHALL, while rst_n = 0 at posedge clk, set cnt_out = 0, tc = 0 and ovf = 0 for all channels, overriding load, enab and ovf_clr.
REQ-028 SHALL resume normal operation on the first posedge with rst_n = 1, with no extra latency.
REQ-029 SHALL leave outputs unknown only before the first reset edge; no asynchronous reset path is permitted.

Structure
REQ-030 SHALL place the direction encodings (UP, DOWN), the mode encodings (WRAP, SAT) and a next-state function type in package counter_pkg.
REQ-031 SHALL implement one channel in sub-module counter_chan (WIDTH parameter), instantiated CHANNELS times via generate.
REQ-032 SHALL compute next state in a single combinational function inside counter_chan, registered in one clocked block.

Verification
REQ-033 SHALL cover: WIDTH=8, ch0 up, wrap, modulus=5, enab held 7 cycles from reset -> cnt 1,2,3,4,5,0,1; tc high only the cycle cnt shows 0; ovf=1 after.
REQ-034 SHALL cover: ch1 down, saturate, load 2, enab 4 cycles -> cnt 2,1,0,0,0; tc pulses on the two cycles after each step at 0; ovf stays 1.
REQ-035 SHALL cover: ch2 load 200 with modulus=10, up, wrap, enab -> next cnt 0, tc=1.
REQ-036 SHALL cover: load and enab together on ch3 with cnt_in=9 -> cnt=9, no increment; rst_n=0 concurrently -> cnt=0, tc=0, ovf=0.
REQ-037 SHALL cover: terminal event and ovf_clr in same cycle -> ovf stays 1; ovf_clr alone next cycle -> ovf=0.
REQ-038 SHALL cover: all four channels enabled simultaneously with differing modes -> each matches an independent reference model every cycle.
